// File: rtl/div_engine_if.sv
// Request/response bundle between the execute-stage control and the divider.
// The slave side is the divider; the master side is the controller.
interface div_engine_if #(parameter int WIDTH = 32);
  logic             start_i;
  logic             signed_i;
  logic             annul_i;
  logic             stall_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             busy_o;
  logic             ready_o;
  logic [WIDTH-1:0] quot_o;
  logic [WIDTH-1:0] rem_o;

  modport slave (
    input  start_i, signed_i, annul_i, stall_i, a_i, b_i,
    output busy_o, ready_o, quot_o, rem_o
  );

  modport master (
    output start_i, signed_i, annul_i, stall_i, a_i, b_i,
    input  busy_o, ready_o, quot_o, rem_o
  );
endinterface

// File: rtl/div_engine.sv
// Multi-cycle radix-2 restoring divider for the execute stage.
// It divides magnitudes, applies the sign fixup on the last step and holds results until the next divide.
module div_engine #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  div_engine_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, stateNext;
  logic [5:0]       cnt;
  logic [WIDTH-1:0] remR, quoR, divR;
  logic             negQ, negR;
  logic [WIDTH-1:0] quotR, remOutR;
  logic             readyR;

  logic             accept, lastIter, divZero;
  logic [WIDTH-1:0] aMag, bMag, remStep, quoStep;
  logic [WIDTH:0]   shifted, diff;

  assign accept   = (state == IDLE) & bus.start_i & ~bus.annul_i;
  assign divZero  = (bus.b_i == '0);
  assign aMag     = (bus.signed_i && bus.a_i[WIDTH-1]) ? -bus.a_i : bus.a_i;
  assign bMag     = (bus.signed_i && bus.b_i[WIDTH-1]) ? -bus.b_i : bus.b_i;

  // The dividend shifts out of quoR's top while quotient bits shift in at bit 0.
  assign shifted  = {remR, quoR[WIDTH-1]};
  assign diff     = shifted - {1'b0, divR};
  assign remStep  = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quoStep  = {quoR[WIDTH-2:0], ~diff[WIDTH]};
  assign lastIter = (cnt == 6'(WIDTH-1));

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (accept) stateNext = divZero ? DONE : RUN;
      RUN:     if (bus.annul_i) stateNext = IDLE;
               else if (lastIter) stateNext = DONE;
      DONE:    if (bus.annul_i || !bus.stall_i) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      remR    <= '0;
      quoR    <= '0;
      divR    <= '0;
      negQ    <= 1'b0;
      negR    <= 1'b0;
      quotR   <= '0;
      remOutR <= '0;
      readyR  <= 1'b0;
    end else begin
      state  <= stateNext;
      readyR <= (stateNext == DONE);
      if (accept) begin
        remR <= '0;
        quoR <= aMag;
        divR <= bMag;
        negQ <= bus.signed_i & (bus.a_i[WIDTH-1] ^ bus.b_i[WIDTH-1]);
        negR <= bus.signed_i & bus.a_i[WIDTH-1];
        cnt  <= '0;
        if (divZero) begin
          quotR   <= '0;
          remOutR <= '0;
        end
      end else if (state == RUN && !bus.annul_i) begin
        remR <= remStep;
        quoR <= quoStep;
        cnt  <= cnt + 6'd1;
        // Remainder takes the dividend's sign so that a == q*b + r holds.
        if (lastIter) begin
          quotR   <= negQ ? -quoStep : quoStep;
          remOutR <= negR ? -remStep : remStep;
        end
      end
    end
  end

  assign bus.busy_o  = rst & (accept | (state == RUN));
  assign bus.ready_o = readyR;
  assign bus.quot_o  = quotR;
  assign bus.rem_o   = remOutR;
endmodule
